// File: rtl/alu_req_sched_if.sv
// Bundle between requesters, the shared ALU and the response consumer.
// The slave modport is the scheduler's view; master is the surrounding system.
interface alu_req_sched_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CMD_WIDTH  = 4,
   parameter int NUM_REQ    = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            req_mode;
   logic [NUM_REQ-1:0]            req_cin;
   logic [2*NUM_REQ-1:0]          req_inp_valid;
   logic [CMD_WIDTH*NUM_REQ-1:0]  req_cmd;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_opa;
   logic [DATA_WIDTH*NUM_REQ-1:0] req_opb;

   logic                  alu_ce;
   logic                  alu_mode;
   logic                  alu_cin;
   logic [1:0]            alu_inp_valid;
   logic [CMD_WIDTH-1:0]  alu_cmd;
   logic [DATA_WIDTH-1:0] alu_opa;
   logic [DATA_WIDTH-1:0] alu_opb;
   logic [DATA_WIDTH:0]   alu_res;
   logic                  alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [DATA_WIDTH:0]   rsp_res;
   logic [5:0]            rsp_flags;
   logic                  busy;

   modport slave (
      input  req_valid, req_mode, req_cin, req_inp_valid, req_cmd, req_opa, req_opb,
      output req_ready,
      output alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
      input  alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err,
      output rsp_valid, rsp_id, rsp_res, rsp_flags, busy,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_mode, req_cin, req_inp_valid, req_cmd, req_opa, req_opb,
      input  req_ready,
      input  alu_ce, alu_mode, alu_cin, alu_inp_valid, alu_cmd, alu_opa, alu_opb,
      output alu_res, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_err,
      input  rsp_valid, rsp_id, rsp_res, rsp_flags, busy,
      output rsp_ready
   );
endinterface

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters, one op in
// flight; results come back on a single response channel tagged with the id.
module alu_req_sched #(
   parameter int          DATA_WIDTH   = 8,
   parameter int          CMD_WIDTH    = 4,
   parameter int          NUM_REQ      = 4,
   parameter int          ALU_LAT      = 1,
   parameter int          MUL_LAT      = 2,
   parameter logic [15:0] MUL_CMD_MASK = 16'h0600
) (
   input logic       clk,
   input logic       rst,
   alu_req_sched_if.slave bus
);
   localparam int         ID_W      = $clog2(NUM_REQ);
   localparam logic [3:0] ALU_LAT_V = 4'(ALU_LAT);
   localparam logic [3:0] MUL_LAT_V = 4'(MUL_LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr;
   int                    grant_idx;
   logic                  any_valid;
   logic                  accept;
   logic                  capture;

   logic                  p_mode, p_cin;
   logic [1:0]            p_inp_valid;
   logic [CMD_WIDTH-1:0]  p_cmd;
   logic [DATA_WIDTH-1:0] p_opa, p_opb;
   logic [ID_W-1:0]       p_id;

   logic [3:0]            lat;
   logic [3:0]            cnt;
   logic [DATA_WIDTH:0]   r_res;
   logic [5:0]            r_flags;
   logic [ID_W-1:0]       r_id;

   // Scan downward so the last hit is the requester closest after rr_ptr.
   always_comb begin
      grant_idx = 0;
      any_valid = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            grant_idx = (int'(rr_ptr) + i) % NUM_REQ;
            any_valid = 1'b1;
         end
      end
   end

   assign lat = (p_mode && MUL_CMD_MASK[p_cmd]) ? MUL_LAT_V : ALU_LAT_V;

   always_comb begin
      state_d       = state_q;
      bus.req_ready = '0;
      accept        = 1'b0;
      capture       = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               accept                   = 1'b1;
               bus.req_ready[grant_idx] = 1'b1;
               state_d                  = ISSUE;
            end
         end
         ISSUE: begin
            if (lat == 4'd1) begin
               capture = 1'b1;
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // cnt holds the number of WAIT cycles still to go after the current one,
   // so the capture edge lands exactly lat clocks after entering ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= ID_W'(NUM_REQ - 1);
         p_mode      <= 1'b0;
         p_cin       <= 1'b0;
         p_inp_valid <= 2'b00;
         p_cmd       <= '0;
         p_opa       <= '0;
         p_opb       <= '0;
         p_id        <= '0;
         cnt         <= '0;
         r_res       <= '0;
         r_flags     <= '0;
         r_id        <= '0;
      end else begin
         if (accept) begin
            p_mode      <= bus.req_mode[grant_idx];
            p_cin       <= bus.req_cin[grant_idx];
            p_inp_valid <= bus.req_inp_valid[grant_idx*2 +: 2];
            p_cmd       <= bus.req_cmd[grant_idx*CMD_WIDTH +: CMD_WIDTH];
            p_opa       <= bus.req_opa[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            p_opb       <= bus.req_opb[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            p_id        <= grant_idx[ID_W-1:0];
            rr_ptr      <= grant_idx[ID_W-1:0];
         end
         if (state_q == ISSUE)     cnt <= lat - 4'd2;
         else if (state_q == WAIT) cnt <= cnt - 4'd1;
         if (capture) begin
            r_res   <= bus.alu_res;
            r_flags <= {bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_l, bus.alu_e, bus.alu_err};
            r_id    <= p_id;
         end
      end
   end

   // Operands keep their last value between ops; only ce and inp_valid drop.
   assign bus.alu_ce        = (state_q == ISSUE) || (state_q == WAIT);
   assign bus.alu_inp_valid = bus.alu_ce ? p_inp_valid : 2'b00;
   assign bus.alu_mode      = p_mode;
   assign bus.alu_cin       = p_cin;
   assign bus.alu_cmd       = p_cmd;
   assign bus.alu_opa       = p_opa;
   assign bus.alu_opb       = p_opb;

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_id    = r_id;
   assign bus.rsp_res   = r_res;
   assign bus.rsp_flags = r_flags;
   assign bus.busy      = (state_q != IDLE);
endmodule
